// File: rtl/conv_pkg.sv
// Shared state type and word helpers for conv_layer_seq.
// Build option: CONV_SATURATE_EN selects saturating rather than wrapping word reduction.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, FWD, BWD, DONE} state_t;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    // Result is sign-extended to 64 bits; callers keep the low w bits.
    function automatic logic signed [63:0] reduce_word(input logic signed [63:0] v,
                                                       input int unsigned w);
`ifdef CONV_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single signed multiply-accumulate shared by the forward and kernel-update passes.
// sum is the value the accumulator takes on this edge, exposed for same-cycle writeback.
module conv_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clear,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] sum
);
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] acc;

    always_comb begin
        prod = a * b;
        sum  = (clear ? '0 : acc) + ACC_WIDTH'(prod);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/conv_layer_seq.sv
// Sequential single-MAC convolution layer with optional gradient kernel update.
// Build option: CONV_SATURATE_EN (see conv_pkg) chooses saturating word reduction.
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int FRAC_BITS        = 0,
    parameter int NUM_KERNELS      = 2,
    parameter int KERNEL_DIM       = 3,
    parameter int INPUT_DIM_WIDTH  = 3,
    parameter int INPUT_DIM_HEIGHT = 3,
    parameter int LR_SHIFT         = 0,
    localparam int OW = INPUT_DIM_WIDTH - KERNEL_DIM + 1,
    localparam int OH = INPUT_DIM_HEIGHT - KERNEL_DIM + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    load_kernels,
    input  logic signed [WIDTH-1:0] input_image   [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
    input  logic signed [WIDTH-1:0] input_kernels [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM],
    input  logic signed [WIDTH-1:0] output_error  [NUM_KERNELS][OH][OW],
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] output_data    [NUM_KERNELS][OH][OW],
    output logic signed [WIDTH-1:0] output_kernels [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM]
);
    localparam int AW = acc_width(WIDTH, KERNEL_DIM * KERNEL_DIM);
    localparam int CW = 16;

    state_t          state;
    logic            mode_q;
    logic            load_q;
    logic [CW-1:0]   kc, oy, ox, ky, kx;
    logic [CW-1:0]   iy, ix;
    logic            at_k, at_oy, at_ox, at_ky, at_kx;
    logic            first_tap, last_tap, final_step, mac_en;
    logic signed [WIDTH-1:0] pix, kern, err, mac_a, mac_b;
    logic signed [AW-1:0]    sum;

    always_comb begin
        at_k  = (kc == CW'(NUM_KERNELS - 1));
        at_oy = (oy == CW'(OH - 1));
        at_ox = (ox == CW'(OW - 1));
        at_ky = (ky == CW'(KERNEL_DIM - 1));
        at_kx = (kx == CW'(KERNEL_DIM - 1));
        mac_en     = (state == FWD) || (state == BWD);
        first_tap  = (state == FWD) ? (ky == '0 && kx == '0) : (oy == '0 && ox == '0);
        last_tap   = (state == FWD) ? (at_ky && at_kx) : (at_oy && at_ox);
        final_step = at_k && at_oy && at_ox && at_ky && at_kx;
        iy = oy + ky;
        ix = ox + kx;
        // Operand selection by comparison keeps every index a constant.
        pix  = '0;
        kern = '0;
        err  = '0;
        for (int unsigned y = 0; y < INPUT_DIM_HEIGHT; y++)
            for (int unsigned x = 0; x < INPUT_DIM_WIDTH; x++)
                if (iy == CW'(y) && ix == CW'(x)) pix = input_image[y][x];
        for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
            for (int unsigned r = 0; r < KERNEL_DIM; r++)
                for (int unsigned c = 0; c < KERNEL_DIM; c++)
                    if (kc == CW'(k) && ky == CW'(r) && kx == CW'(c)) kern = output_kernels[k][r][c];
            for (int unsigned r = 0; r < OH; r++)
                for (int unsigned c = 0; c < OW; c++)
                    if (kc == CW'(k) && oy == CW'(r) && ox == CW'(c)) err = output_error[k][r][c];
        end
        mac_a = (state == BWD) ? err : pix;
        mac_b = (state == BWD) ? pix : kern;
    end

    conv_mac #(.WIDTH(WIDTH), .ACC_WIDTH(AW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clear (first_tap),
        .a     (mac_a),
        .b     (mac_b),
        .sum   (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
            load_q <= 1'b0;
            kc <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0;
            for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
                for (int unsigned r = 0; r < OH; r++)
                    for (int unsigned c = 0; c < OW; c++) output_data[k][r][c] <= '0;
                for (int unsigned r = 0; r < KERNEL_DIM; r++)
                    for (int unsigned c = 0; c < KERNEL_DIM; c++) output_kernels[k][r][c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    busy   <= 1'b1;
                    mode_q <= mode;
                    load_q <= load_kernels;
                end
                LOAD: begin
                    if (load_q) output_kernels <= input_kernels;
                    kc <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0;
                    state <= FWD;
                end
                FWD: begin
                    if (last_tap)
                        for (int unsigned k = 0; k < NUM_KERNELS; k++)
                            for (int unsigned r = 0; r < OH; r++)
                                for (int unsigned c = 0; c < OW; c++)
                                    if (kc == CW'(k) && oy == CW'(r) && ox == CW'(c))
                                        output_data[k][r][c] <= WIDTH'(reduce_word(64'(sum >>> FRAC_BITS), WIDTH));
                    if (final_step) begin
                        kc <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0;
                        if (mode_q) state <= BWD;
                        else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        kx <= at_kx ? '0 : kx + 1'b1;
                        if (at_kx) begin
                            ky <= at_ky ? '0 : ky + 1'b1;
                            if (at_ky) begin
                                ox <= at_ox ? '0 : ox + 1'b1;
                                if (at_ox) begin
                                    oy <= at_oy ? '0 : oy + 1'b1;
                                    if (at_oy) kc <= kc + 1'b1;
                                end
                            end
                        end
                    end
                end
                BWD: begin
                    if (last_tap)
                        for (int unsigned k = 0; k < NUM_KERNELS; k++)
                            for (int unsigned r = 0; r < KERNEL_DIM; r++)
                                for (int unsigned c = 0; c < KERNEL_DIM; c++)
                                    if (kc == CW'(k) && ky == CW'(r) && kx == CW'(c))
                                        output_kernels[k][r][c] <= WIDTH'(reduce_word(
                                            64'(kern) - 64'((sum >>> FRAC_BITS) >>> LR_SHIFT), WIDTH));
                    if (final_step) begin
                        kc <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ox <= at_ox ? '0 : ox + 1'b1;
                        if (at_ox) begin
                            oy <= at_oy ? '0 : oy + 1'b1;
                            if (at_oy) begin
                                kx <= at_kx ? '0 : kx + 1'b1;
                                if (at_kx) begin
                                    ky <= at_ky ? '0 : ky + 1'b1;
                                    if (at_ky) kc <= kc + 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_seq.sv
// Self-checking bench for conv_layer_seq against an arithmetic reference model.
module tb_conv_layer_seq;
    localparam int NK = 2, K = 3, H = 3, WD = 3, OH = 1, OW = 1;
    localparam int NF = NK * OH * OW * K * K;
    localparam int NB = NF;

    logic clk = 1'b0;
    logic rst, start, mode, load_kernels, busy, done;
    logic signed [7:0] input_image    [H][WD];
    logic signed [7:0] input_kernels  [NK][K][K];
    logic signed [7:0] output_error   [NK][OH][OW];
    logic signed [7:0] output_data    [NK][OH][OW];
    logic signed [7:0] output_kernels [NK][K][K];

    longint mk [NK][K][K];
    longint mo [NK][OH][OW];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_layer_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .load_kernels(load_kernels),
        .input_image(input_image), .input_kernels(input_kernels), .output_error(output_error),
        .busy(busy), .done(done), .output_data(output_data), .output_kernels(output_kernels)
    );

    function automatic longint red(input longint v);
`ifdef CONV_SATURATE_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        return ((v % 256) + 384) % 256 - 128;
`endif
    endfunction

    // Reference: forward correlation, then optional gradient step (FRAC_BITS=0, LR_SHIFT=0).
    task automatic model_op(input bit m, input bit ld);
        longint s;
        if (ld)
            for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++)
                mk[k][r][c] = input_kernels[k][r][c];
        for (int k = 0; k < NK; k++) for (int y = 0; y < OH; y++) for (int x = 0; x < OW; x++) begin
            s = 0;
            for (int r = 0; r < K; r++) for (int c = 0; c < K; c++)
                s += longint'(input_image[y + r][x + c]) * mk[k][r][c];
            mo[k][y][x] = red(s);
        end
        if (m)
            for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
                s = 0;
                for (int y = 0; y < OH; y++) for (int x = 0; x < OW; x++)
                    s += longint'(output_error[k][y][x]) * input_image[y + r][x + c];
                mk[k][r][c] = red(mk[k][r][c] - s);
            end
    endtask

    // Issues one start from IDLE and returns edges from acceptance (counted as 1) to done; -1 on timeout.
    task automatic do_op(input bit m, input bit ld, output int lat);
        @(negedge clk);
        while (busy || done) @(negedge clk);
        mode = m; load_kernels = ld; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 1'b0; load_kernels = 1'b0;
        for (int y = 0; y < H; y++) for (int x = 0; x < WD; x++) input_image[y][x] = 8'sd0;
        for (int k = 0; k < NK; k++) begin
            output_error[k][0][0] = 8'sd0;
            for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) input_kernels[k][r][c] = 8'sd0;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
        end
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (output_data[k][0][0] !== 8'sd0 || output_kernels[k][1][1] !== 8'sd0) begin
                n_fail++; $display("FAIL reset_regs k=%0d data=%0d kern=%0d required 0", k,
                                   output_data[k][0][0], output_kernels[k][1][1]);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b required 0", busy); end
        for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) mk[k][r][c] = 0;
    endtask

    task automatic test_forward;
        int lat;
        for (int y = 0; y < H; y++) for (int x = 0; x < WD; x++) input_image[y][x] = 8'(y * 3 + x);
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
            input_kernels[0][r][c] = 8'(r);
            input_kernels[1][r][c] = 8'(-r);
        end
        do_op(1'b0, 1'b1, lat);
        model_op(1'b0, 1'b1);
        n_checks++;
        if (lat !== NF + 2) begin n_fail++; $display("FAIL fwd_latency got=%0d required %0d", lat, NF + 2); end
        n_checks++;
        if (output_data[0][0][0] !== 8'sd54 || output_data[1][0][0] !== -8'sd54) begin
            n_fail++; $display("FAIL fwd_data got=%0d,%0d required 54,-54", output_data[0][0][0], output_data[1][0][0]);
        end
        for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
            n_checks++;
            if (output_kernels[k][r][c] !== 8'(mk[k][r][c])) begin
                n_fail++; $display("FAIL fwd_kern[%0d][%0d][%0d] got=%0d required %0d", k, r, c,
                                   output_kernels[k][r][c], mk[k][r][c]);
            end
        end
    endtask

    task automatic test_update;
        int lat;
        int kexp [NK][K][K] = '{'{'{0, -1, -2}, '{-2, -3, -4}, '{-4, -5, -6}},
                                '{'{0, -2, -4}, '{-7, -9, -11}, '{-14, -16, -18}}};
        output_error[0][0][0] = 8'sd1;
        output_error[1][0][0] = 8'sd2;
        do_op(1'b1, 1'b1, lat);
        model_op(1'b1, 1'b1);
        n_checks++;
        if (lat !== NF + NB + 2) begin n_fail++; $display("FAIL upd_latency got=%0d required %0d", lat, NF + NB + 2); end
        n_checks++;
        if (output_data[0][0][0] !== 8'(mo[0][0][0]) || output_data[1][0][0] !== 8'(mo[1][0][0])) begin
            n_fail++; $display("FAIL upd_data got=%0d,%0d required %0d,%0d", output_data[0][0][0],
                               output_data[1][0][0], mo[0][0][0], mo[1][0][0]);
        end
        for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
            n_checks++;
            if (output_kernels[k][r][c] !== 8'(kexp[k][r][c])) begin
                n_fail++; $display("FAIL upd_kern[%0d][%0d][%0d] got=%0d required %0d", k, r, c,
                                   output_kernels[k][r][c], kexp[k][r][c]);
            end
        end
    endtask

    task automatic test_reuse;
        int lat;
        do_op(1'b0, 1'b0, lat);
        model_op(1'b0, 1'b0);
        n_checks++;
        if (lat !== NF + 2) begin n_fail++; $display("FAIL reuse_latency got=%0d required %0d", lat, NF + 2); end
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (output_data[k][0][0] !== 8'(mo[k][0][0])) begin
                n_fail++; $display("FAIL reuse_data[%0d] got=%0d required %0d", k, output_data[k][0][0], mo[k][0][0]);
            end
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic signed [7:0] exp_v;
`ifdef CONV_SATURATE_EN
        exp_v = 8'sd127;
`else
        exp_v = 8'sd9;
`endif
        for (int y = 0; y < H; y++) for (int x = 0; x < WD; x++) input_image[y][x] = 8'sd127;
        for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++)
            input_kernels[k][r][c] = 8'sd127;
        do_op(1'b0, 1'b1, lat);
        model_op(1'b0, 1'b1);
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (output_data[k][0][0] !== exp_v) begin
                n_fail++; $display("FAIL overflow[%0d] got=%0d required %0d", k, output_data[k][0][0], exp_v);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        for (int y = 0; y < H; y++) for (int x = 0; x < WD; x++) input_image[y][x] = 8'($urandom_range(0, 15)) - 8'sd8;
        output_error[0][0][0] = 8'sd3;
        output_error[1][0][0] = -8'sd1;
        @(negedge clk);
        while (busy || done) @(negedge clk);
        mode = 1'b1; load_kernels = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == 6);
        end
        start = 1'b0;
        model_op(1'b1, 1'b0);
        n_checks++;
        if (!done || lat !== NF + NB + 2) begin
            n_fail++; $display("FAIL ignored_start_latency got=%0d required %0d", lat, NF + NB + 2);
        end
        for (int k = 0; k < NK; k++) for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
            n_checks++;
            if (output_kernels[k][r][c] !== 8'(mk[k][r][c])) begin
                n_fail++; $display("FAIL ignored_start_kern[%0d][%0d][%0d] got=%0d required %0d", k, r, c,
                                   output_kernels[k][r][c], mk[k][r][c]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        while (busy || done) @(negedge clk);
        mode = 1'b0; load_kernels = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!done && lat < 300) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== NF + 2) begin n_fail++; $display("FAIL b2b_first_latency got=%0d required %0d", lat, NF + 2); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap busy=%b done=%b required 0 0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept busy=%b required 1", busy); end
        lat = 1;
        while (!done && lat < 300) begin @(posedge clk); #1; lat++; end
        model_op(1'b0, 1'b0);
        n_checks++;
        if (lat !== NF + 2) begin n_fail++; $display("FAIL b2b_second_latency got=%0d required %0d", lat, NF + 2); end
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (output_data[k][0][0] !== 8'(mo[k][0][0])) begin
                n_fail++; $display("FAIL b2b_data[%0d] got=%0d required %0d", k, output_data[k][0][0], mo[k][0][0]);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        bit m, ld;
        for (int it = 0; it < 5; it++) begin
            for (int y = 0; y < H; y++) for (int x = 0; x < WD; x++) input_image[y][x] = 8'($urandom);
            for (int k = 0; k < NK; k++) begin
                output_error[k][0][0] = 8'($urandom);
                for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) input_kernels[k][r][c] = 8'($urandom);
            end
            m  = 1'($urandom_range(0, 1));
            ld = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_op(m, ld, lat);
            model_op(m, ld);
            n_checks++;
            if (lat !== (m ? NF + NB + 2 : NF + 2)) begin
                n_fail++; $display("FAIL rand%0d_latency got=%0d mode=%0d", it, lat, m);
            end
            for (int k = 0; k < NK; k++) begin
                n_checks++;
                if (output_data[k][0][0] !== 8'(mo[k][0][0])) begin
                    n_fail++; $display("FAIL rand%0d_data[%0d] got=%0d required %0d", it, k, output_data[k][0][0], mo[k][0][0]);
                end
                for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
                    n_checks++;
                    if (output_kernels[k][r][c] !== 8'(mk[k][r][c])) begin
                        n_fail++; $display("FAIL rand%0d_kern[%0d][%0d][%0d] got=%0d required %0d", it, k, r, c,
                                           output_kernels[k][r][c], mk[k][r][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        @(negedge clk);
        while (busy || done) @(negedge clk);
        mode = 1'b1; load_kernels = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags busy=%b done=%b required 0 0", busy, done);
        end
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (output_data[k][0][0] !== 8'sd0) begin
                n_fail++; $display("FAIL midrst_data[%0d] got=%0d required 0", k, output_data[k][0][0]);
            end
            for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) begin
                n_checks++;
                if (output_kernels[k][r][c] !== 8'sd0) begin
                    n_fail++; $display("FAIL midrst_kern[%0d][%0d][%0d] got=%0d required 0", k, r, c, output_kernels[k][r][c]);
                end
            end
        end
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_done activity=%0d required 0", pulses); end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_update;
        test_reuse;
        test_overflow;
        test_start_ignored;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
